// File: rtl/traffic_pkg.sv
// Shared types and constants for the farm-road detector and the traffic-light controller.
package traffic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    SERVE = 2'd2
  } det_state_e;

  localparam int unsigned DEB_CYC_DEF = 4;
  localparam int unsigned GAP_CYC_DEF = 3;
  localparam int unsigned CNT_W_DEF   = 3;

  // Controller light timing, in controller ticks.
  localparam int unsigned T_LONG  = 30;
  localparam int unsigned T_SHORT = 15;
  localparam int unsigned T_AMBER = 5;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/farm_car_detector_if.sv
// Signals exchanged between the detector, the loop sensor and the traffic-light controller.
interface farm_car_detector_if
  import traffic_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
);
  logic             loop_raw;
  logic             FG;
  logic             c;
  logic [CNT_W-1:0] car_cnt;
  logic             ovf;

  modport master (output loop_raw, output FG, input c, input car_cnt, input ovf);
  modport slave  (input loop_raw, input FG, output c, output car_cnt, output ovf);
endinterface

// File: rtl/loop_debouncer.sv
// Two-flop synchroniser plus stability counter; pulses arrive on each qualified rising level.
module loop_debouncer
  import traffic_pkg::*;
#(
  parameter int unsigned DEB_CYC = DEB_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic loop_raw,
  output logic loop_db,
  output logic arrive
);
  localparam int unsigned  DW       = cnt_width(DEB_CYC);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);

  logic          s1_q, s1_d;
  logic          loop_s_q, loop_s_d;
  logic          loop_db_q, loop_db_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;

  always_comb begin
    s1_d      = loop_raw;
    loop_s_d  = s1_q;
    loop_db_d = loop_db_q;
    deb_cnt_d = '0;
    if (loop_s_q != loop_db_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        loop_db_d = ~loop_db_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= 1'b0;
      loop_s_q  <= 1'b0;
      loop_db_q <= 1'b0;
      deb_cnt_q <= '0;
    end else begin
      s1_q      <= s1_d;
      loop_s_q  <= loop_s_d;
      loop_db_q <= loop_db_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  assign loop_db = loop_db_q;
  assign arrive  = loop_s_q && !loop_db_q && (deb_cnt_q == DEB_LAST);

endmodule

// File: rtl/farm_car_detector.sv
// Farm-road car request: counts debounced arrivals, discharges one car per GAP_CYC cycles of FG.
module farm_car_detector
  import traffic_pkg::*;
#(
  parameter int unsigned DEB_CYC = DEB_CYC_DEF,
  parameter int unsigned GAP_CYC = GAP_CYC_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input logic                clk,
  input logic                rst,
  farm_car_detector_if.slave bus
);
  localparam int unsigned      GAP_W    = cnt_width(GAP_CYC);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  det_state_e       state_q, state_d;
  logic [CNT_W-1:0] car_cnt_q, car_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             ovf_q, ovf_d;
  logic             loop_db, arrive, gap_en, depart;

  loop_debouncer #(.DEB_CYC(DEB_CYC)) u_deb (
    .clk      (clk),
    .rst      (rst),
    .loop_raw (bus.loop_raw),
    .loop_db  (loop_db),
    .arrive   (arrive)
  );

  always_comb begin
    // The WAIT->SERVE edge already counts as the first FG cycle, so departures
    // land on FG edges GAP_CYC, 2*GAP_CYC, ... after the controller goes green.
    gap_en    = bus.FG && (state_q == SERVE || state_q == WAIT);
    depart    = gap_en && (state_q == SERVE) && (gap_cnt_q == GAP_LAST) && (car_cnt_q != '0);
    gap_cnt_d = '0;
    if (gap_en && gap_cnt_q != GAP_LAST) gap_cnt_d = gap_cnt_q + 1'b1;

    car_cnt_d = car_cnt_q;
    ovf_d     = ovf_q;
    if (arrive && !depart) begin
      if (car_cnt_q == CNT_MAX) ovf_d = 1'b1;
      else                      car_cnt_d = car_cnt_q + 1'b1;
    end else if (depart && !arrive) begin
      car_cnt_d = car_cnt_q - 1'b1;
    end

    state_d = state_q;
    unique case (state_q)
      IDLE:    if (car_cnt_d != '0) state_d = bus.FG ? SERVE : WAIT;
      WAIT:    if (bus.FG) state_d = SERVE;
      SERVE: begin
        if (car_cnt_d == '0) state_d = IDLE;
        else if (!bus.FG)    state_d = WAIT;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      car_cnt_q <= '0;
      gap_cnt_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      car_cnt_q <= car_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      ovf_q     <= ovf_d;
    end
  end

  // A qualified rise can only start from a low debounced level.
  always_comb assert (!(arrive && loop_db));

  assign bus.c       = (car_cnt_q != '0);
  assign bus.car_cnt = car_cnt_q;
  assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_farm_car_detector.sv
// Directed scenarios plus random loop/FG traffic against a behavioural queue model.
module tb_farm_car_detector;
  import traffic_pkg::*;

  localparam int DEB = 4;
  localparam int GAP = 3;
  localparam int CW  = 3;
  localparam int MAXC = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  farm_car_detector_if #(.CNT_W(CW)) bus ();

  farm_car_detector #(.DEB_CYC(DEB), .GAP_CYC(GAP), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: raw level seen two edges late; level accepted after DEB
  // consecutive disagreeing edges; one car leaves every GAP-th FG edge of a served queue.
  int pipe[2];
  int m_db, m_run, m_streak, m_cnt, m_ovf, m_state;

  always @(posedge clk) begin
    int s, arr, dep, n;
    if (rst) begin
      pipe[0] = 0; pipe[1] = 0;
      m_db = 0; m_run = 0; m_streak = 0; m_cnt = 0; m_ovf = 0; m_state = 0;
    end else begin
      s = pipe[1];
      arr = 0;
      if (s != m_db) begin
        m_run++;
        if (m_run == DEB) begin
          m_db  = s;
          m_run = 0;
          arr   = s;
        end
      end else begin
        m_run = 0;
      end
      dep = 0;
      if (bus.FG && m_cnt > 0) begin
        m_streak++;
        if (m_state == 2 && (m_streak % GAP) == 0) dep = 1;
      end else begin
        m_streak = 0;
      end
      n = m_cnt + arr - dep;
      if (n > MAXC) begin
        n = MAXC;
        m_ovf = 1;
      end
      case (m_state)
        0: if (n > 0) m_state = bus.FG ? 2 : 1;
        1: if (bus.FG) m_state = 2;
        default: if (n == 0) m_state = 0; else if (!bus.FG) m_state = 1;
      endcase
      m_cnt = n;
      pipe[1] = pipe[0];
      pipe[0] = int'(bus.loop_raw);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("car_cnt", 32'(bus.car_cnt), 32'(m_cnt));
      chk("c", 32'(bus.c), 32'(m_cnt != 0));
      chk("ovf", 32'(bus.ovf), 32'(m_ovf));
      chk("state", 32'(dut.state_q), 32'(m_state));
      chk("deb_cnt", 32'(dut.u_deb.deb_cnt_q), 32'(m_run));
      chk("gap_cnt", 32'(dut.gap_cnt_q), 32'(m_streak % GAP));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic add_car();
    bus.loop_raw = 1'b1;
    tick(7);
    bus.loop_raw = 1'b0;
    tick(7);
  endtask

  initial begin
    rst = 1'b1;
    bus.loop_raw = 1'b0;
    bus.FG = 1'b0;
    tick(2);
    chk_en = 1;
    chk("reset_cnt", 32'(bus.car_cnt), 32'd0);
    chk("reset_c", 32'(bus.c), 32'd0);

    // Loop held high from edge 0: request appears after edge DEB+1.
    rst = 1'b0;
    bus.loop_raw = 1'b1;
    tick(5);
    chk("lat_cnt_e4", 32'(bus.car_cnt), 32'd0);
    chk("lat_c_e4", 32'(bus.c), 32'd0);
    tick(1);
    chk("lat_cnt_e5", 32'(bus.car_cnt), 32'd1);
    chk("lat_c_e5", 32'(bus.c), 32'd1);
    chk("lat_state", 32'(dut.state_q), 32'(WAIT));
    bus.loop_raw = 1'b0;
    tick(8);

    // Glitch of two cycles is rejected.
    bus.loop_raw = 1'b1;
    tick(2);
    bus.loop_raw = 1'b0;
    tick(8);
    chk("glitch_cnt", 32'(bus.car_cnt), 32'd1);
    chk("glitch_deb", 32'(dut.u_deb.deb_cnt_q), 32'd0);

    // Full discharge of three cars.
    add_car();
    add_car();
    chk("q3", 32'(bus.car_cnt), 32'd3);
    bus.FG = 1'b1;
    tick(3); chk("dis_e3", 32'(bus.car_cnt), 32'd2);
    tick(3); chk("dis_e6", 32'(bus.car_cnt), 32'd1);
    tick(3); chk("dis_e9", 32'(bus.car_cnt), 32'd0);
    chk("dis_c", 32'(bus.c), 32'd0);
    chk("dis_state", 32'(dut.state_q), 32'(IDLE));
    bus.FG = 1'b0;
    tick(2);

    // FG dropped mid-gap.
    add_car(); add_car(); add_car();
    bus.FG = 1'b1;
    tick(4);
    bus.FG = 1'b0;
    tick(1);
    chk("part_cnt", 32'(bus.car_cnt), 32'd2);
    chk("part_state", 32'(dut.state_q), 32'(WAIT));
    chk("part_gap", 32'(dut.gap_cnt_q), 32'd0);
    chk("part_c", 32'(bus.c), 32'd1);
    bus.FG = 1'b1;
    tick(2); chk("refg_e2", 32'(bus.car_cnt), 32'd2);
    tick(1); chk("refg_e3", 32'(bus.car_cnt), 32'd1);
    bus.FG = 1'b0;

    // Saturation and sticky overflow.
    rst = 1'b1; tick(1); rst = 1'b0;
    for (int i = 0; i < 7; i++) add_car();
    chk("sat7_cnt", 32'(bus.car_cnt), 32'd7);
    chk("sat7_ovf", 32'(bus.ovf), 32'd0);
    add_car();
    chk("sat8_cnt", 32'(bus.car_cnt), 32'd7);
    chk("sat8_ovf", 32'(bus.ovf), 32'd1);
    tick(5);
    chk("ovf_sticky", 32'(bus.ovf), 32'd1);
    rst = 1'b1; tick(1);
    chk("rst_cnt", 32'(bus.car_cnt), 32'd0);
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
    rst = 1'b0;

    // Arrival coinciding with a departure, then reset mid-SERVE.
    add_car(); add_car(); add_car();
    bus.FG = 1'b1;
    bus.loop_raw = 1'b1;
    tick(3); chk("coin_e3", 32'(bus.car_cnt), 32'd2);
    tick(3); chk("coin_e6", 32'(bus.car_cnt), 32'd2);
    chk("coin_state", 32'(dut.state_q), 32'(SERVE));
    tick(1);
    rst = 1'b1; tick(1);
    chk("mid_rst_cnt", 32'(bus.car_cnt), 32'd0);
    chk("mid_rst_c", 32'(bus.c), 32'd0);
    chk("mid_rst_state", 32'(dut.state_q), 32'(IDLE));
    rst = 1'b0;
    tick(6);
    chk("requal_cnt", 32'(bus.car_cnt), 32'd1);
    chk("requal_state", 32'(dut.state_q), 32'(SERVE));
    bus.loop_raw = 1'b0;
    bus.FG = 1'b0;

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) < 2);
      bus.loop_raw = $urandom_range(0, 1);
      bus.FG = ($urandom_range(0, 2) == 0);
      tick($urandom_range(1, 9));
    end
    rst = 1'b0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
